// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit between the memory stage and a word-wide dmem
// Sub-word stores are done as read-modify-write so dmem only ever sees whole-word accesses.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == 2'b11) || (size == 2'b01 && offset[0]) ||
               (size == 2'b10 && offset != 2'b00);
    endfunction

    // Aligned halves sit at offset 0 or 2, so one byte-granular shift serves both sizes.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] offset, input logic uns);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        result  = word;
        if (size == 2'b00)
            result = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (size == 2'b01)
            result = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        return result;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wdata,
                                          input logic [1:0] size, input logic [1:0] offset);
        logic [31:0] result;
        result = word;
        if (size == 2'b00)
            result[{offset, 3'b000} +: 8] = wdata[7:0];
        else
            result[{offset[1], 4'b0000} +: 16] = wdata;
        return result;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_misaligned  <= 1'b0;
            mem_enable       <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            offset_q         <= 2'b00;
            wdata_q          <= '0;
        end else begin
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    req_ready   <= 1'b0;
                    write_q     <= req_write;
                    size_q      <= req_size;
                    unsigned_q  <= req_unsigned;
                    offset_q    <= req_addr[1:0];
                    wdata_q     <= req_wdata[15:0];
                    mem_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state           <= RESP;
                        resp_valid      <= 1'b1;
                        resp_misaligned <= 1'b1;
                    end else if (req_write && req_size == 2'b10) begin
                        state            <= WR;
                        mem_enable       <= 1'b1;
                        mem_write_enable <= 1'b1;
                        mem_data_in      <= req_wdata;
                    end else begin
                        state           <= RD;
                        mem_enable      <= 1'b1;
                        mem_read_enable <= 1'b1;
                    end
                end
                RD: begin
                    state           <= WAIT;
                    mem_enable      <= 1'b0;
                    mem_read_enable <= 1'b0;
                end
                WAIT: if (write_q) begin
                    state            <= WR;
                    mem_enable       <= 1'b1;
                    mem_write_enable <= 1'b1;
                    mem_data_in      <= merge(mem_data_out, wdata_q, size_q, offset_q);
                end else begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= extract(mem_data_out, size_q, offset_q, unsigned_q);
                end
                WR: begin
                    state            <= RESP;
                    mem_enable       <= 1'b0;
                    mem_write_enable <= 1'b0;
                    resp_valid       <= 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a small dmem model
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned;
    logic [31:0] resp_rdata;
    logic        mem_enable, mem_write_enable, mem_read_enable;
    logic [31:0] mem_address, mem_data_in, mem_data_out;

    int errors = 0;
    int checks = 0;

    int          rec_resp, rec_wr, rec_rd;
    logic [31:0] rec_data;
    logic        rec_mis, rec_en, rec_both;

    logic [31:0] dmem [0:15];
    logic [1:0]  bad_size [3];
    logic [31:0] bad_addr [3];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_enable && mem_write_enable) dmem[mem_address[5:2]] <= mem_data_in;
        if (mem_enable && mem_read_enable)  mem_data_out <= dmem[mem_address[5:2]];
    end

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .mem_enable(mem_enable),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_data_out(mem_data_out)
    );

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_before_issue got=%b exp=1", req_ready);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clock);
        #1 req_valid = 1'b0;
        rec_resp = -1; rec_wr = -1; rec_rd = -1; rec_en = 1'b0; rec_both = 1'b0;
        rec_data = 'x; rec_mis = 1'bx;
        for (int n = 1; n <= 8 && rec_resp < 0; n++) begin
            @(negedge clock);
            if (mem_write_enable && rec_wr < 0) rec_wr = n;
            if (mem_read_enable && rec_rd < 0) rec_rd = n;
            if (mem_enable) rec_en = 1'b1;
            if (mem_write_enable && mem_read_enable) rec_both = 1'b1;
            if (resp_valid) begin
                rec_resp = n; rec_data = resp_rdata; rec_mis = resp_misaligned;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({req_ready, resp_valid, resp_misaligned} !== 3'b100) begin
            errors++; $display("FAIL reset_flags got=%b exp=100", {req_ready, resp_valid, resp_misaligned});
        end
        checks++;
        if ({mem_enable, mem_write_enable, mem_read_enable} !== 3'b000 || resp_rdata !== 32'h0 ||
            mem_address !== 32'h0 || mem_data_in !== 32'h0) begin
            errors++; $display("FAIL reset_outputs got en=%b we=%b re=%b rdata=%h addr=%h din=%h exp all 0",
                mem_enable, mem_write_enable, mem_read_enable, resp_rdata, mem_address, mem_data_in);
        end
        reset = 1'b1;
    endtask

    task automatic test_word;
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
        checks++;
        if (rec_wr !== 1 || rec_resp !== 2 || rec_rd !== -1 || rec_data !== 32'h0) begin
            errors++; $display("FAIL sw_timing got wr=%0d resp=%0d rd=%0d rdata=%h exp wr=1 resp=2 rd=-1 rdata=0",
                rec_wr, rec_resp, rec_rd, rec_data);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        checks++;
        if (rec_rd !== 1 || rec_resp !== 3 || rec_data !== 32'h12345678 || rec_mis !== 1'b0) begin
            errors++; $display("FAIL lw_basic got rd=%0d resp=%0d rdata=%h mis=%b exp rd=1 resp=3 rdata=12345678 mis=0",
                rec_rd, rec_resp, rec_data, rec_mis);
        end
    endtask

    task automatic test_load_extend;
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h98765432);
        do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
        checks++;
        if (rec_data !== 32'hFFFFFF98) begin
            errors++; $display("FAIL lb_signed got=%h exp=ffffff98", rec_data);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
        checks++;
        if (rec_data !== 32'h00000098) begin
            errors++; $display("FAIL lbu got=%h exp=00000098", rec_data);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rec_data !== 32'h00005432) begin
            errors++; $display("FAIL lh_low got=%h exp=00005432", rec_data);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        checks++;
        if (rec_data !== 32'hFFFF9876) begin
            errors++; $display("FAIL lh_high_signed got=%h exp=ffff9876", rec_data);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        checks++;
        if (rec_data !== 32'h00000054) begin
            errors++; $display("FAIL lb_lane1 got=%h exp=00000054", rec_data);
        end
    endtask

    task automatic test_subword_store;
        do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'hFFFFFFAB);
        checks++;
        if (rec_rd !== 1 || rec_wr !== 3 || rec_resp !== 4 || rec_both !== 1'b0) begin
            errors++; $display("FAIL sb_sequence got rd=%0d wr=%0d resp=%0d both=%b exp rd=1 wr=3 resp=4 both=0",
                rec_rd, rec_wr, rec_resp, rec_both);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rec_data !== 32'h9876AB32) begin
            errors++; $display("FAIL sb_merge got=%h exp=9876ab32", rec_data);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h5555BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        checks++;
        if (rec_data !== 32'hBEEFAB32) begin
            errors++; $display("FAIL sh_merge got=%h exp=beefab32", rec_data);
        end
    endtask

    task automatic test_misaligned;
        bad_size = '{2'b10, 2'b01, 2'b11};
        bad_addr = '{32'h2, 32'h3, 32'h0};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, bad_size[i], 1'b0, bad_addr[i], 32'h0);
            checks++;
            if (rec_resp !== 1 || rec_mis !== 1'b1 || rec_data !== 32'h0 || rec_en !== 1'b0) begin
                errors++; $display("FAIL misaligned_%0d got resp=%0d mis=%b rdata=%h en=%b exp resp=1 mis=1 rdata=0 en=0",
                    i, rec_resp, rec_mis, rec_data, rec_en);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h0000BEEF;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, mem_enable, mem_write_enable, mem_read_enable} !== 5'b10000 ||
            mem_address !== 32'h0) begin
            errors++; $display("FAIL reset_async got ready=%b rv=%b en=%b we=%b re=%b addr=%h exp ready=1 others 0",
                req_ready, resp_valid, mem_enable, mem_write_enable, mem_read_enable, mem_address);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL reset_release got ready=%b we=%b exp ready=1 we=0", req_ready, mem_write_enable);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        checks++;
        if (rec_data !== 32'h11223344) begin
            errors++; $display("FAIL reset_no_write got=%h exp=11223344", rec_data);
        end
    endtask

    task automatic test_back_to_back;
        int   ready_seen;
        logic rd4, rd5, rv3, rv7;
        logic [31:0] data7;
        ready_seen = 0; rd4 = 1'b0; rd5 = 1'b0; rv3 = 1'b0; rv7 = 1'b0; data7 = 'x;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clock);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clock);
            if (n <= 3 && req_ready) ready_seen++;
            if (n == 3) rv3 = resp_valid;
            if (n == 4) begin rd4 = mem_read_enable; if (!req_ready) ready_seen += 10; end
            if (n == 5) begin rd5 = mem_read_enable; req_valid = 1'b0; end
            if (n == 7) begin rv7 = resp_valid; data7 = resp_rdata; end
        end
        checks++;
        if (ready_seen !== 0) begin
            errors++; $display("FAIL b2b_ready got code=%0d exp=0 (busy 1..3, ready 4)", ready_seen);
        end
        checks++;
        if ({rv3, rd4, rd5, rv7} !== 4'b1011 || data7 !== 32'h12345678) begin
            errors++; $display("FAIL b2b_second got rv3=%b rd4=%b rd5=%b rv7=%b data=%h exp 1 0 1 1 12345678",
                rv3, rd4, rd5, rv7, data7);
        end
        @(negedge clock);
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        test_reset();
        test_word();
        test_load_extend();
        test_subword_store();
        test_misaligned();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
